alu_accumulator_seq: RTL and testbench

- Sequencing stage directly upstream of the combinational 16-bit ALU (add/sub/mul/div/mod, 32-bit result, 2-bit error). Also captures that ALU's result downstream.
- Accepts one command at a time over a valid/ready handshake and drives the ALU operands, with the accumulator's low 16 bits as operand A.
- Waits a fixed settle time, then registers the ALU result into a 32-bit accumulator and reports the result and error status as a one-cycle pulse.

---
 rtl/alu_accumulator_seq_pkg.sv | 32 +++
 rtl/alu_accumulator_seq_decode.sv | 22 ++
 rtl/alu_accumulator_seq.sv | 149 ++++++++++++++
 tb/tb_alu_accumulator_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_accumulator_seq_pkg.sv
// Shared definitions for the ALU accumulator sequencer.
// Contents:
//   - opcode values accepted on cmd_op
//   - the sequencer state enum
//   - the completion status codes reported on res_err
package alu_accumulator_seq_pkg;

    // ALU opcodes; these are forwarded unchanged to the ALU.
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MOD   = 4'd4;

    // Local opcodes; these complete inside the sequencer.
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_CLEAR = 4'd9;
    localparam logic [3:0] OP_NOP   = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERROR = 2'd2
    } state_t;

    // Completion status codes.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OVF     = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

endpackage

// File: rtl/alu_accumulator_seq_decode.sv
// acc_op_decode: combinational classification of a command opcode.
// Ports:
//   cmd_op     in  4  opcode to classify
//   is_alu     out 1  opcode is forwarded to the ALU (add/sub/mul/div/mod)
//   is_local   out 1  opcode completes locally (LOAD/CLEAR/NOP)
//   is_illegal out 1  opcode is neither of the above
module acc_op_decode
    import alu_accumulator_seq_pkg::*;
(
    input  logic [3:0] cmd_op,
    output logic       is_alu,
    output logic       is_local,
    output logic       is_illegal
);

    always_comb begin
        is_alu     = (cmd_op <= OP_MOD);
        is_local   = (cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR) || (cmd_op == OP_NOP);
        is_illegal = !is_alu && !is_local;
    end

endmodule

// File: rtl/alu_accumulator_seq.sv
// alu_accumulator_seq: sequences one command at a time into a combinational
// 16-bit ALU, waits SETTLE cycles, then captures the ALU result into a 32-bit
// accumulator and reports it with a one-cycle completion pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op, cmd_operand      opcode and operand B (or LOAD value)
//   alu_a, alu_b, alu_op     registered ALU inputs (alu_a = acc[15:0])
//   alu_result, alu_err      ALU outputs (alu_err[1] = divide/mod by zero)
//   acc                      accumulator
//   res_valid/res_data/res_err  completion pulse, value and status
//   ovf_sticky               set by any overflow, cleared by LOAD/CLEAR/rst
//   busy                     an ALU operation is in flight
module alu_accumulator_seq
    import alu_accumulator_seq_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_operand,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_err,
    output logic [31:0] acc,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [1:0]  res_err,
    output logic        ovf_sticky,
    output logic        busy
);

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       is_alu;
    logic       is_local;
    logic       is_illegal;
    logic       accept;
    logic       cap_ovf;
    logic       unused_alu_err0;

    // Only bit 1 of the ALU error code matters to this stage.
    assign unused_alu_err0 = alu_err[0];

    acc_op_decode u_decode (
        .cmd_op     (cmd_op),
        .is_alu     (is_alu),
        .is_local   (is_local),
        .is_illegal (is_illegal)
    );

    // Result does not fit a signed 16-bit value: the upper 17 bits are not a
    // pure sign extension.
    function automatic logic ovf_s16(input logic signed [31:0] r);
        return !((r[31:15] == 17'h00000) || (r[31:15] == 17'h1FFFF));
    endfunction

    assign cmd_ready = ((state == IDLE) || (state == ERROR)) && !rst;
    assign busy      = (state == ISSUE);
    assign accept    = cmd_valid && cmd_ready;
    assign cap_ovf   = (alu_op <= OP_MUL) && ovf_s16(signed'(alu_result));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            alu_op     <= 4'd0;
            acc        <= 32'd0;
            res_valid  <= 1'b0;
            res_data   <= 32'd0;
            res_err    <= ERR_NONE;
            ovf_sticky <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE, ERROR: begin
                    if (accept) begin
                        if (is_alu) begin
                            if (state == IDLE) begin
                                // Issue: drive the ALU and start the settle count.
                                alu_a  <= acc[15:0];
                                alu_b  <= cmd_operand;
                                alu_op <= cmd_op;
                                cnt    <= 4'd0;
                                state  <= ISSUE;
                            end else begin
                                // Blocked while in ERROR: complete without issuing.
                                res_valid <= 1'b1;
                                res_data  <= acc;
                                res_err   <= ERR_DIV0;
                            end
                        end else if (is_illegal) begin
                            res_valid <= 1'b1;
                            res_data  <= acc;
                            res_err   <= ERR_ILLEGAL;
                        end else if (is_local) begin
                            res_valid <= 1'b1;
                            res_err   <= ERR_NONE;
                            if (cmd_op == OP_LOAD) begin
                                acc        <= {16'd0, cmd_operand};
                                res_data   <= {16'd0, cmd_operand};
                                ovf_sticky <= 1'b0;
                                state      <= IDLE;
                            end else if (cmd_op == OP_CLEAR) begin
                                acc        <= 32'd0;
                                res_data   <= 32'd0;
                                ovf_sticky <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                res_data <= acc;
                            end
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 4'd1;
                    // Capture boundary: ALU output has settled.
                    if (cnt == LAST_CNT) begin
                        res_valid <= 1'b1;
                        if (alu_err[1]) begin
                            res_data <= acc;
                            res_err  <= ERR_DIV0;
                            state    <= ERROR;
                        end else begin
                            acc      <= alu_result;
                            res_data <= alu_result;
                            res_err  <= cap_ovf ? ERR_OVF : ERR_NONE;
                            if (cap_ovf) begin
                                ovf_sticky <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_accumulator_seq.sv
module tb_alu_accumulator_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_operand;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [1:0]  alu_err;
    logic [31:0] acc;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_err;
    logic        ovf_sticky;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int pulses;

    always #5 clk = ~clk;

    alu_accumulator_seq #(.SETTLE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_err     (alu_err),
        .acc         (acc),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_err     (res_err),
        .ovf_sticky  (ovf_sticky),
        .busy        (busy)
    );

    // Combinational signed 16-bit ALU with 32-bit result.
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    assign sa = {{16{alu_a[15]}}, alu_a};
    assign sb = {{16{alu_b[15]}}, alu_b};

    always_comb begin
        alu_result = 32'd0;
        alu_err    = 2'b00;
        case (alu_op)
            4'd0: alu_result = sa + sb;
            4'd1: alu_result = sa - sb;
            4'd2: alu_result = sa * sb;
            4'd3: if (sb == 0) alu_err = 2'b10; else alu_result = sa / sb;
            4'd4: if (sb == 0) alu_err = 2'b10; else alu_result = sa % sb;
            default: alu_err = 2'b01;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a command, wait for accept, then wait for the completion pulse.
    // lat = cycles from the accept edge to res_valid being seen high.
    task automatic send(input logic [3:0] op, input logic [15:0] operand, output int l);
        int n;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = operand;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        l = 0;
        while (!res_valid && l < 50) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (l >= 50) check("res_valid_timeout", 32'(l), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        cmd_operand = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_acc", acc, 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_ovf", 32'(ovf_sticky), 32'd0);

        // 1. LOAD 11
        send(4'd8, 16'd11, lat);
        check("load_lat", 32'(lat), 32'd0);
        check("load_data", res_data, 32'd11);
        check("load_err", 32'(res_err), 32'd0);
        check("load_acc", acc, 32'd11);
        check("load_ready", 32'(cmd_ready), 32'd1);

        // 2. ADD 15, SUB 30
        send(4'd0, 16'd15, lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_alu_a", 32'(alu_a), 32'd11);
        check("add_alu_b", 32'(alu_b), 32'd15);
        check("add_alu_op", 32'(alu_op), 32'd0);
        check("add_data", res_data, 32'd26);
        send(4'd1, 16'd30, lat);
        check("sub_alu_a", 32'(alu_a), 32'd26);
        check("sub_data", res_data, 32'hFFFF_FFFC);
        check("sub_err", 32'(res_err), 32'd0);

        // 3. Overflow and sticky flag
        send(4'd8, 16'd32000, lat);
        send(4'd2, 16'd16000, lat);
        check("mul_data", res_data, 32'h1E84_8000);
        check("mul_err", 32'(res_err), 32'd1);
        check("mul_sticky", 32'(ovf_sticky), 32'd1);
        check("mul_acc", acc, 32'h1E84_8000);
        send(4'd0, 16'd0, lat);
        check("ovf_next_alu_a", 32'(alu_a), 32'h8000);
        check("ovf_next_data", res_data, 32'hFFFF_8000);
        check("ovf_next_err", 32'(res_err), 32'd0);
        check("sticky_hold", 32'(ovf_sticky), 32'd1);
        send(4'd8, 16'd5, lat);
        check("sticky_clr", 32'(ovf_sticky), 32'd0);

        // 4. Divide by zero, ERROR state, exit by CLEAR
        send(4'd8, 16'd11, lat);
        send(4'd3, 16'd0, lat);
        check("div0_err", 32'(res_err), 32'd2);
        check("div0_acc", acc, 32'd11);
        @(negedge clk);
        check("div0_ready", 32'(cmd_ready), 32'd1);
        check("div0_busy", 32'(busy), 32'd0);
        send(4'd0, 16'd1, lat);
        check("blk_lat", 32'(lat), 32'd0);
        check("blk_err", 32'(res_err), 32'd2);
        check("blk_acc", acc, 32'd11);
        check("blk_alu_op", 32'(alu_op), 32'd3);
        check("blk_alu_b", 32'(alu_b), 32'd0);
        send(4'd9, 16'd0, lat);
        check("clr_acc", acc, 32'd0);
        check("clr_err", 32'(res_err), 32'd0);
        send(4'd0, 16'd4, lat);
        check("post_clr_add", res_data, 32'd4);
        check("post_clr_err", 32'(res_err), 32'd0);

        // 5. Illegal opcode, NOP, MOD, held cmd_valid
        send(4'd6, 16'd99, lat);
        check("ill_lat", 32'(lat), 32'd0);
        check("ill_err", 32'(res_err), 32'd3);
        check("ill_acc", acc, 32'd4);
        send(4'd10, 16'd77, lat);
        check("nop_err", 32'(res_err), 32'd0);
        check("nop_data", res_data, 32'd4);
        send(4'd8, 16'd17, lat);
        send(4'd4, 16'd5, lat);
        check("mod_data", res_data, 32'd2);
        send(4'd3, 16'd5, lat);
        check("div_data", res_data, 32'd0);
        send(4'd8, 16'd4, lat);

        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = 4'd0;
        cmd_operand = 16'd1;
        pulses      = 0;
        @(posedge clk);
        #1;
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        if (res_valid) pulses++;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (res_valid) pulses++;
        end
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_acc", acc, 32'd5);
        check("hold_idle", 32'(busy), 32'd0);

        // 6. Reset during ISSUE
        send(4'd8, 16'd7, lat);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = 4'd0;
        cmd_operand = 16'd3;
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_acc", acc, 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_alu", {alu_a, alu_b[11:0], alu_op}, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_no_pulse", 32'(res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
